// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux channel multiplexer: mode encodings
// and the scan sequencer state encoding.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Sequencer decision for the current edge: keep dwelling or take a sample.
  typedef enum logic {
    ST_DWELL  = 1'b0,
    ST_SAMPLE = 1'b1
  } seq_st_t;

endpackage

// File: rtl/scan_ctr.sv
// Scan sequencer for scan_mux: walks the channels in turn, holding each one
// for dwell+1 enabled cycles, and flags the sampling edge and sweep wrap.
// The mode-change detector clears the sequencer so scan always starts at
// channel 0 with a full dwell.
module scan_ctr
  import scan_mux_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   scan_ch,
  output logic               sample_now,
  output logic               wrap_now
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]   scan_ch_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic               mode_prev_r;
  logic               mode_chg_s;
  seq_st_t            seq_st_s;

  // Decide whether this edge dwells or samples; a mode-change edge never samples.
  always_comb begin
    mode_chg_s = (mode != mode_prev_r);
    if (en && (mode == MODE_SCAN) && !mode_chg_s && (dwell_cnt_r >= dwell)) begin
      seq_st_s = ST_SAMPLE;
    end else begin
      seq_st_s = ST_DWELL;
    end
  end

  assign sample_now = (seq_st_s == ST_SAMPLE);
  assign wrap_now   = sample_now && (scan_ch_r == LAST_CH);
  assign scan_ch    = scan_ch_r;

  // Sequencer state: channel and dwell counters plus previous-mode tracking.
  // During reset the current mode is captured so that leaving reset is not
  // seen as a mode change and the first scan sample lands after dwell+1 edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_ch_r   <= '0;
      dwell_cnt_r <= '0;
      mode_prev_r <= mode;
    end else if (en) begin
      mode_prev_r <= mode;
      if (mode_chg_s) begin
        scan_ch_r   <= '0;
        dwell_cnt_r <= '0;
      end else if (mode == MODE_SCAN) begin
        case (seq_st_s)
          ST_SAMPLE: begin
            dwell_cnt_r <= '0;
            scan_ch_r   <= (scan_ch_r == LAST_CH) ? '0 : scan_ch_r + SEL_W'(1);
          end
          ST_DWELL: begin
            dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
          end
          default: begin
            dwell_cnt_r <= '0;
            scan_ch_r   <= '0;
          end
        endcase
      end else begin
        scan_ch_r   <= scan_ch_r;
        dwell_cnt_r <= dwell_cnt_r;
      end
    end else begin
      scan_ch_r   <= scan_ch_r;
      dwell_cnt_r <= dwell_cnt_r;
      mode_prev_r <= mode_prev_r;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select and automatic scan.
// The selected channel, its index and one-cycle valid/wrap strobes are all
// registered, so nothing on the inputs reaches the outputs combinationally.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int W       = 1,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   d,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                en,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    ch,
  output logic                valid,
  output logic                wrap
);

  logic [SEL_W-1:0] scan_ch_s;
  logic             sample_now_s;
  logic             wrap_now_s;
  logic [SEL_W-1:0] idx_s;
  logic [W-1:0]     pick_s;
  logic             sel_ok_s;
  logic             load_s;

  scan_ctr #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W)
  ) u_scan_ctr (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .en         (en),
    .dwell      (dwell),
    .scan_ch    (scan_ch_s),
    .sample_now (sample_now_s),
    .wrap_now   (wrap_now_s)
  );

  // Channel selection: pick the index by mode, range-check sel, and AND-OR
  // mux so a select beyond N_CH can never read past the packed input.
  always_comb begin
    idx_s    = (mode == MODE_SCAN) ? scan_ch_s : sel;
    sel_ok_s = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
    load_s   = sample_now_s || (en && (mode == MODE_MANUAL) && sel_ok_s);
    pick_s   = '0;
    for (int i = 0; i < N_CH; i++) begin
      pick_s = pick_s | ({W{idx_s == SEL_W'(i)}} & d[i*W +: W]);
    end
  end

  // Output registers: load on a manual or scan sample, otherwise hold data
  // and drop the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (load_s) begin
      y     <= pick_s;
      ch    <= idx_s;
      valid <= 1'b1;
      wrap  <= wrap_now_s;
    end else begin
      y     <= y;
      ch    <= ch;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule
